// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: round-robin arbiter in front of one shared external ALU.
// Two requesters compete for the ALU. The winner's operands and opcode are
// registered onto alu_a/alu_b/alu_op. The ALU result and flags are captured
// one cycle later and held until the consumer acknowledges them.
// Optional feature: define ALU_ARBITER_STICKY_EN to accumulate carry and
// overflow into sticky_cv. Without it, sticky_cv is tied to zero.
module alu_arbiter_ctrl #(
  parameter int M   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [M-1:0]   a0,
  input  logic [M-1:0]   b0,
  input  logic [M-1:0]   a1,
  input  logic [M-1:0]   b1,
  input  logic [OPW-1:0] op0,
  input  logic [OPW-1:0] op1,
  output logic [1:0]     gnt,
  output logic [M-1:0]   alu_a,
  output logic [M-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [M-1:0]   alu_r,
  input  logic           alu_c,
  input  logic           alu_n,
  input  logic           alu_v,
  input  logic           alu_z,
  output logic [M-1:0]   res,
  output logic [3:0]     flags,
  output logic           res_valid,
  input  logic           res_ack,
  output logic [1:0]     sticky_cv,
  input  logic           clr_sticky
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // prio = 1 means requester 1 wins a tie; it points at whoever was not granted last.
  logic prio;
  logic any_req;
  logic win;

  // Pick the winner: a lone request always wins, a tie goes to the pointer.
  always_comb begin
    any_req = req0 | req1;
    win     = (req0 & req1) ? prio : req1;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment first guarantees every path assigns state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_req) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_ACK;
      WAIT_ACK: if (res_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Grant, operand launch, result capture and acknowledge handshake.
  // NOTE: every register here is plain flops (no memory array), so all of them
  // are cleared by the asynchronous reset. This discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= 2'b00;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res       <= '0;
      flags     <= 4'b0000;
      res_valid <= 1'b0;
      prio      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt    <= win ? 2'b10 : 2'b01;
            alu_a  <= win ? a1 : a0;
            alu_b  <= win ? b1 : b0;
            alu_op <= win ? op1 : op0;
            prio   <= ~win;
          end
        end
        ISSUE: begin
          res       <= alu_r;
          flags     <= {alu_c, alu_n, alu_v, alu_z};
          res_valid <= 1'b1;
        end
        WAIT_ACK: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            gnt       <= 2'b00;
          end
        end
        default: begin
          res_valid <= 1'b0;
          gnt       <= 2'b00;
        end
      endcase
    end
  end

`ifdef ALU_ARBITER_STICKY_EN
  // Accumulate carry/overflow at each capture edge. A clear on the same edge
  // keeps only the freshly captured bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_cv <= 2'b00;
    end else if (state == ISSUE) begin
      sticky_cv <= clr_sticky ? {alu_c, alu_v} : (sticky_cv | {alu_c, alu_v});
    end else if (clr_sticky) begin
      sticky_cv <= 2'b00;
    end
  end
`else
  // Feature disabled: sticky bits are constant zero and the clear input is ignored.
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_cv         = 2'b00;
`endif

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl. An ALU model drives alu_r and the
// flags. A transaction-level reference model predicts the winner, latched
// operands, captured result and sticky bits from the arbitration rules.
module tb_alu_arbiter_ctrl;
  localparam int M   = 4;
  localparam int OPW = 3;
`ifdef ALU_ARBITER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk, rst_n;
  logic req0, req1, res_ack, clr_sticky;
  logic [M-1:0] a0, b0, a1, b1;
  logic [OPW-1:0] op0, op1;
  logic [1:0] gnt, sticky_cv;
  logic [M-1:0] alu_a, alu_b, alu_r, res;
  logic [OPW-1:0] alu_op;
  logic alu_c, alu_n, alu_v, alu_z, res_valid;
  logic [3:0] flags;

  int passed = 0;
  int total  = 0;

  // Reference-model state.
  bit prio_m;             // requester favoured on a tie
  logic [1:0] exp_sticky;
  bit force_en;
  logic [M+3:0] force_val;  // {r, c, n, v, z}
  logic [M+3:0] alu_vec;

  alu_arbiter_ctrl #(.M(M), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
    .res(res), .flags(flags), .res_valid(res_valid), .res_ack(res_ack),
    .sticky_cv(sticky_cv), .clr_sticky(clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU returning {r, c, n, v, z}.
  function automatic logic [M+3:0] alu_fn(input logic [OPW-1:0] op,
                                          input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0] s;
    logic [M-1:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[M-1:0]; c = s[M];
                  v = (a[M-1] == b[M-1]) && (r[M-1] != a[M-1]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[M-1:0]; c = s[M];
                  v = (a[M-1] != b[M-1]) && (r[M-1] != a[M-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = a << 1; c = a[M-1]; end
      default: r = b;
    endcase
    return {r, c, r[M-1], v, (r == '0)};
  endfunction

  always_comb alu_vec = force_en ? force_val : alu_fn(alu_op, alu_a, alu_b);
  assign {alu_r, alu_c, alu_n, alu_v, alu_z} = alu_vec;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: request, grant, capture, hold, acknowledge.
  task automatic do_op(input logic r0, input logic r1,
                       input logic [M-1:0] va0, input logic [M-1:0] vb0, input logic [OPW-1:0] vo0,
                       input logic [M-1:0] va1, input logic [M-1:0] vb1, input logic [OPW-1:0] vo1,
                       input int hold, input bit scramble, output logic [1:0] g);
    bit w;
    logic [M-1:0] ea, eb;
    logic [OPW-1:0] eo;
    logic [M+3:0] ev;
    logic [1:0] eg;
    req0 = r0; req1 = r1; a0 = va0; b0 = vb0; op0 = vo0; a1 = va1; b1 = vb1; op1 = vo1;
    res_ack = 1'b0; clr_sticky = 1'b0;
    w  = (r0 && r1) ? prio_m : r1;
    ea = w ? va1 : va0; eb = w ? vb1 : vb0; eo = w ? vo1 : vo0;
    eg = w ? 2'b10 : 2'b01;
    prio_m = ~w;
    tick();
    g = gnt;
    total++; if (gnt !== eg) $display("FAIL grant: got %b expected %b", gnt, eg); else passed++;
    total++; if ({alu_a, alu_b, alu_op} !== {ea, eb, eo})
      $display("FAIL operands: got %h/%h/%h expected %h/%h/%h", alu_a, alu_b, alu_op, ea, eb, eo);
    else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL early_valid: got %b expected 0", res_valid); else passed++;
    if (scramble) begin
      // Inputs after the grant must not affect the operation; ack here is ignored.
      a0 = M'($urandom); b0 = M'($urandom); a1 = M'($urandom); b1 = M'($urandom);
      op0 = OPW'($urandom); op1 = OPW'($urandom);
      req0 = 1'($urandom); req1 = 1'($urandom);
      res_ack = 1'($urandom); clr_sticky = 1'($urandom);
    end
    ev = force_en ? force_val : alu_fn(eo, ea, eb);
    if (STICKY) exp_sticky = clr_sticky ? {ev[3], ev[1]} : (exp_sticky | {ev[3], ev[1]});
    tick();
    res_ack = 1'b0; clr_sticky = 1'b0;
    total++; if ({res_valid, res, flags} !== {1'b1, ev})
      $display("FAIL capture: got v=%b r=%h f=%b expected v=1 r=%h f=%b", res_valid, res, flags,
               ev[M+3:4], ev[3:0]);
    else passed++;
    total++; if (gnt !== eg) $display("FAIL grant_hold: got %b expected %b", gnt, eg); else passed++;
    total++; if (sticky_cv !== exp_sticky)
      $display("FAIL sticky_capture: got %b expected %b", sticky_cv, exp_sticky);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      tick();
      total++; if ({res_valid, gnt, res, flags} !== {1'b1, eg, ev})
        $display("FAIL wait_hold: got v=%b g=%b r=%h f=%b expected v=1 g=%b r=%h f=%b",
                 res_valid, gnt, res, flags, eg, ev[M+3:4], ev[3:0]);
      else passed++;
    end
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0; req0 = 1'b0; req1 = 1'b0;
    total++; if ({res_valid, gnt, res, flags} !== {1'b0, 2'b00, ev})
      $display("FAIL ack_release: got v=%b g=%b r=%h f=%b expected v=0 g=00 r=%h f=%b",
               res_valid, gnt, res, flags, ev[M+3:4], ev[3:0]);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; res_ack = 0; clr_sticky = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
    force_en = 1'b0; force_val = '0; prio_m = 1'b0; exp_sticky = 2'b00;
    #1;
    total++; if ({gnt, alu_a, alu_b, alu_op, res, flags, res_valid, sticky_cv} !== '0)
      $display("FAIL reset_state: got g=%b a=%h b=%h op=%h r=%h f=%b v=%b s=%b expected all zero",
               gnt, alu_a, alu_b, alu_op, res, flags, res_valid, sticky_cv);
    else passed++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0] g;
    force_en = 1'b1; force_val = {4'h2, 4'b1000};
    do_op(1'b1, 1'b0, 4'h6, 4'hA, 3'd0, 4'h0, 4'h0, 3'd0, 0, 1'b0, g);
    force_en = 1'b0;
  endtask

  task automatic test_idle_ack();
    logic [M-1:0] r_before;
    r_before = res;
    res_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({res_valid, gnt, res} !== {1'b0, 2'b00, r_before})
        $display("FAIL idle_ack: got v=%b g=%b r=%h expected v=0 g=00 r=%h", res_valid, gnt, res, r_before);
      else passed++;
    end
    res_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    logic [1:0] seq [4];
    test_reset();
    for (int i = 0; i < 4; i++)
      do_op(1'b1, 1'b1, M'($urandom), M'($urandom), OPW'($urandom),
            M'($urandom), M'($urandom), OPW'($urandom), 0, 1'b0, seq[i]);
    g = 2'b01;
    for (int i = 0; i < 4; i++) begin
      total++; if (seq[i] !== g) $display("FAIL alternate_%0d: got %b expected %b", i, seq[i], g); else passed++;
      g = ~g;
    end
  endtask

  task automatic test_single_req1();
    logic [1:0] g;
    for (int i = 0; i < 4; i++)
      do_op(1'b0, 1'b1, M'($urandom), M'($urandom), OPW'($urandom),
            M'($urandom), M'($urandom), OPW'($urandom), 5, 1'b0, g);
  endtask

  task automatic test_reset_mid_op();
    logic [1:0] g;
    // Leave the pointer favouring requester 1, then reset inside WAIT_ACK.
    do_op(1'b1, 1'b0, 4'h3, 4'h4, 3'd0, 4'h0, 4'h0, 3'd0, 0, 1'b0, g);
    req0 = 1'b1; a0 = 4'h7; b0 = 4'h7; op0 = 3'd0;
    tick(); tick();
    req0 = 1'b0;
    total++; if (res_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b expected 1", res_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({res_valid, gnt, res, flags, sticky_cv} !== '0)
      $display("FAIL async_reset: got v=%b g=%b r=%h f=%b s=%b expected all zero",
               res_valid, gnt, res, flags, sticky_cv);
    else passed++;
    prio_m = 1'b0; exp_sticky = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({res_valid, gnt} !== 3'b000)
        $display("FAIL post_reset_idle: got v=%b g=%b expected v=0 g=00", res_valid, gnt);
      else passed++;
    end
    do_op(1'b1, 1'b1, 4'h1, 4'h2, 3'd2, 4'h3, 4'h4, 3'd3, 0, 1'b0, g);
  endtask

  task automatic test_sticky();
    logic [1:0] g;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    exp_sticky = 2'b00;
    total++; if (sticky_cv !== 2'b00) $display("FAIL sticky_preclear: got %b expected 00", sticky_cv); else passed++;
    force_en = 1'b1;
    force_val = {4'h5, 4'b1000};
    do_op(1'b1, 1'b0, 4'h1, 4'h1, 3'd0, 4'h0, 4'h0, 3'd0, 1, 1'b0, g);
    force_val = {4'h3, 4'b0010};
    do_op(1'b0, 1'b1, 4'h0, 4'h0, 3'd0, 4'h2, 4'h1, 3'd1, 1, 1'b0, g);
    force_en = 1'b0;
    total++; if (sticky_cv !== (STICKY ? 2'b11 : 2'b00))
      $display("FAIL sticky_accum: got %b expected %b", sticky_cv, STICKY ? 2'b11 : 2'b00);
    else passed++;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    exp_sticky = 2'b00;
    total++; if (sticky_cv !== 2'b00) $display("FAIL sticky_clear: got %b expected 00", sticky_cv); else passed++;
  endtask

  task automatic test_random();
    logic [1:0] g;
    int rq;
    for (int n = 0; n < 40; n++) begin
      rq = int'($urandom_range(1, 3));
      do_op(rq[0], rq[1], M'($urandom), M'($urandom), OPW'($urandom),
            M'($urandom), M'($urandom), OPW'($urandom),
            int'($urandom_range(0, 3)), 1'b1, g);
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_ack();
    test_back_to_back();
    test_single_req1();
    test_random();
    test_sticky();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
